flght_cmd_ctrl: RTL and testbench

Parametrised command configurator for the quadcopter flight controller. It decodes remote commands from the UART command path, holds the desired pitch, roll, yaw and thrust setpoints, and sequences inertial calibration. Beyond the basic configurator it adds configurable setpoint and thrust widths, a NACK response for illegal opcodes, calibration abort, and a comm-loss watchdog that ramps thrust to zero. It sits between the command receiver and the flight_cntrl/inertial_integrator blocks.

---
 rtl/flght_cmd_pkg.sv | 24 ++
 rtl/flght_cmd_ctrl_sat_tmr.sv | 26 ++
 rtl/flght_cmd_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_flght_cmd_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flght_cmd_pkg.sv
// Shared opcode/state encodings and default response bytes for the flight command controller.
package flght_cmd_pkg;

    typedef enum logic [7:0] {
        OpSetPtch  = 8'h02,
        OpSetRoll  = 8'h03,
        OpSetYaw   = 8'h04,
        OpSetThrst = 8'h05,
        OpCalibrate = 8'h06,
        OpEmerLand = 8'h07,
        OpMtrsOff  = 8'h08
    } opcode_e;

    typedef enum logic [1:0] {
        StIdle,
        StCalSpin,
        StCalWait,
        StResp
    } state_e;

    localparam logic [7:0] RESP_ACK  = 8'hA5;
    localparam logic [7:0] RESP_NACK = 8'hEE;

endpackage

// File: rtl/flght_cmd_ctrl_sat_tmr.sv
// Clearable, enabled up-counter that saturates at all-ones and flags the terminal count.
module sat_tmr #(
    parameter int unsigned W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !done) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign done = &cnt_q;

endmodule

// File: rtl/flght_cmd_ctrl.sv
// Remote command decoder: holds attitude/thrust setpoints, sequences inertial calibration and
// ramps thrust down when the command link goes quiet.
module flght_cmd_ctrl
    import flght_cmd_pkg::*;
#(
    parameter int unsigned SP_W      = 16,
    parameter int unsigned THR_W     = 9,
    parameter int unsigned THR_MAX   = 400,
    parameter int unsigned SPIN_W    = 26,
    parameter int unsigned WDOG_W    = 24,
    parameter int unsigned RAMP_W    = 12,
    parameter int unsigned RAMP_STEP = 4,
    parameter logic [7:0]  ACK       = RESP_ACK,
    parameter logic [7:0]  NACK      = RESP_NACK
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_rdy,
    input  logic [7:0]              cmd,
    input  logic [15:0]             data,
    input  logic                    cal_done,
    output logic                    clr_cmd_rdy,
    output logic [7:0]              resp,
    output logic                    send_resp,
    output logic signed [SP_W-1:0]  d_ptch,
    output logic signed [SP_W-1:0]  d_roll,
    output logic signed [SP_W-1:0]  d_yaw,
    output logic [THR_W-1:0]        thrst,
    output logic                    strt_cal,
    output logic                    inertial_cal,
    output logic                    motors_off,
    output logic                    comm_lost
);

    localparam logic [THR_W-1:0] THR_MAX_C = THR_W'(THR_MAX);
    localparam logic [THR_W-1:0] STEP_C    = THR_W'(RAMP_STEP);

    state_e            state_q, state_d;
    logic [SP_W-1:0]   ptch_q, ptch_d, roll_q, roll_d, yaw_q, yaw_d;
    logic [THR_W-1:0]  thrst_q, thrst_d;
    logic [7:0]        resp_q, resp_d;
    logic              moff_q, moff_d;
    logic              cal_q, cal_d;
    logic              lost_q, lost_d;

    logic              spin_clr, spin_en, spin_done;
    logic              wdog_clr, wdog_en, wdog_done;
    logic              ramp_clr, ramp_en, ramp_done, ramp_tick;
    logic [THR_W-1:0]  thr_set, thr_dec;

    assign spin_en   = (state_q == StCalSpin);
    assign wdog_en   = (state_q == StIdle) && !moff_q;
    assign ramp_en   = lost_q && !moff_q;
    assign ramp_tick = ramp_en && ramp_done;
    // Restarting on each tick gives a period of exactly 2**RAMP_W cycles.
    assign ramp_clr  = !lost_q || ramp_tick;

    assign thr_set = (data[THR_W-1:0] > THR_MAX_C) ? THR_MAX_C : data[THR_W-1:0];
    assign thr_dec = (thrst_q > STEP_C) ? (thrst_q - STEP_C) : '0;

    sat_tmr #(.W(SPIN_W)) u_spin_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (spin_clr),
        .en    (spin_en),
        .done  (spin_done)
    );

    sat_tmr #(.W(WDOG_W)) u_wdog_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (wdog_clr),
        .en    (wdog_en),
        .done  (wdog_done)
    );

    sat_tmr #(.W(RAMP_W)) u_ramp_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ramp_clr),
        .en    (ramp_en),
        .done  (ramp_done)
    );

    always_comb begin
        state_d     = state_q;
        ptch_d      = ptch_q;
        roll_d      = roll_q;
        yaw_d       = yaw_q;
        thrst_d     = thrst_q;
        resp_d      = resp_q;
        moff_d      = moff_q;
        cal_d       = cal_q;
        lost_d      = lost_q;
        clr_cmd_rdy = 1'b0;
        strt_cal    = 1'b0;
        spin_clr    = 1'b0;
        wdog_clr    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_rdy) begin
                    // An accepted command always beats a same-cycle watchdog expiry.
                    clr_cmd_rdy = 1'b1;
                    wdog_clr    = 1'b1;
                    lost_d      = 1'b0;
                    resp_d      = ACK;
                    state_d     = StResp;
                    case (cmd)
                        OpSetPtch:  ptch_d  = data[SP_W-1:0];
                        OpSetRoll:  roll_d  = data[SP_W-1:0];
                        OpSetYaw:   yaw_d   = data[SP_W-1:0];
                        OpSetThrst: thrst_d = thr_set;
                        OpCalibrate: begin
                            moff_d   = 1'b0;
                            cal_d    = 1'b1;
                            spin_clr = 1'b1;
                            state_d  = StCalSpin;
                        end
                        OpEmerLand: begin
                            ptch_d  = '0;
                            roll_d  = '0;
                            yaw_d   = '0;
                            thrst_d = '0;
                        end
                        OpMtrsOff: begin
                            moff_d  = 1'b1;
                            thrst_d = '0;
                        end
                        default: resp_d = NACK;
                    endcase
                end else if (lost_q) begin
                    if (ramp_tick) begin
                        thrst_d = thr_dec;
                        if (thr_dec == '0) begin
                            moff_d = 1'b1;
                        end
                    end
                end else if (wdog_done && !moff_q) begin
                    lost_d = 1'b1;
                    ptch_d = '0;
                    roll_d = '0;
                    yaw_d  = '0;
                end
            end
            StCalSpin, StCalWait: begin
                // Only MTRS_OFF may interrupt calibration; anything else waits pending.
                if (cmd_rdy && (cmd == OpMtrsOff)) begin
                    clr_cmd_rdy = 1'b1;
                    wdog_clr    = 1'b1;
                    lost_d      = 1'b0;
                    moff_d      = 1'b1;
                    thrst_d     = '0;
                    cal_d       = 1'b0;
                    resp_d      = ACK;
                    state_d     = StResp;
                end else if ((state_q == StCalSpin) && spin_done) begin
                    strt_cal = 1'b1;
                    state_d  = StCalWait;
                end else if ((state_q == StCalWait) && cal_done) begin
                    cal_d   = 1'b0;
                    resp_d  = ACK;
                    state_d = StResp;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptch_q  <= '0;
            roll_q  <= '0;
            yaw_q   <= '0;
            thrst_q <= '0;
            resp_q  <= 8'h00;
            moff_q  <= 1'b1;
            cal_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptch_q  <= ptch_d;
            roll_q  <= roll_d;
            yaw_q   <= yaw_d;
            thrst_q <= thrst_d;
            resp_q  <= resp_d;
            moff_q  <= moff_d;
            cal_q   <= cal_d;
            lost_q  <= lost_d;
        end
    end

    assign send_resp    = (state_q == StResp);
    assign resp         = resp_q;
    assign d_ptch       = ptch_q;
    assign d_roll       = roll_q;
    assign d_yaw        = yaw_q;
    assign thrst        = thrst_q;
    assign inertial_cal = cal_q;
    assign motors_off   = moff_q;
    assign comm_lost    = lost_q;

endmodule

// File: tb/tb_flght_cmd_ctrl.sv
// Directed, table-driven bench for flght_cmd_ctrl with small timer widths.
module tb_flght_cmd_ctrl;

    localparam int unsigned SP_W      = 12;
    localparam int unsigned THR_W     = 9;
    localparam int unsigned THR_MAX   = 400;
    localparam int unsigned SPIN_W    = 9;
    localparam int unsigned WDOG_W    = 6;
    localparam int unsigned RAMP_W    = 3;
    localparam int unsigned RAMP_STEP = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_rdy = 1'b0;
    logic [7:0]        cmd = 8'h00;
    logic [15:0]       data = 16'h0000;
    logic              cal_done = 1'b0;
    logic              clr_cmd_rdy, send_resp, strt_cal, inertial_cal, motors_off, comm_lost;
    logic [7:0]        resp;
    logic [SP_W-1:0]   d_ptch, d_roll, d_yaw;
    logic [THR_W-1:0]  thrst;

    int n_checks = 0;
    int n_fail = 0;

    flght_cmd_ctrl #(
        .SP_W      (SP_W),
        .THR_W     (THR_W),
        .THR_MAX   (THR_MAX),
        .SPIN_W    (SPIN_W),
        .WDOG_W    (WDOG_W),
        .RAMP_W    (RAMP_W),
        .RAMP_STEP (RAMP_STEP),
        .ACK       (8'hA5),
        .NACK      (8'hEE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_rdy      (cmd_rdy),
        .cmd          (cmd),
        .data         (data),
        .cal_done     (cal_done),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .resp         (resp),
        .send_resp    (send_resp),
        .d_ptch       (d_ptch),
        .d_roll       (d_roll),
        .d_yaw        (d_yaw),
        .thrst        (thrst),
        .strt_cal     (strt_cal),
        .inertial_cal (inertial_cal),
        .motors_off   (motors_off),
        .comm_lost    (comm_lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]       op;
        logic [15:0]      d;
        logic [7:0]       resp;
        logic [SP_W-1:0]  p;
        logic [SP_W-1:0]  r;
        logic [SP_W-1:0]  y;
        logic [THR_W-1:0] t;
        logic             moff;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ptch"}, 32'(d_ptch), 0);
        chk({tag, "_roll"}, 32'(d_roll), 0);
        chk({tag, "_yaw"}, 32'(d_yaw), 0);
        chk({tag, "_thrst"}, 32'(thrst), 0);
        chk({tag, "_moff"}, 32'(motors_off), 1);
        chk({tag, "_lost"}, 32'(comm_lost), 0);
        chk({tag, "_resp"}, 32'(resp), 0);
        chk({tag, "_send"}, 32'(send_resp), 0);
        chk({tag, "_clr"}, 32'(clr_cmd_rdy), 0);
        chk({tag, "_strt"}, 32'(strt_cal), 0);
        chk({tag, "_ical"}, 32'(inertial_cal), 0);
    endtask

    // Drives a command in the current (IDLE) cycle and leaves time just after the accepting edge.
    task automatic accept(input logic [7:0] op, input logic [15:0] d, input string tag);
        cmd_rdy = 1'b1;
        cmd     = op;
        data    = d;
        #1;
        chk({tag, "_clr"}, 32'(clr_cmd_rdy), 1);
        chk({tag, "_nosend"}, 32'(send_resp), 0);
        step();
        cmd_rdy = 1'b0;
        #1;
    endtask

    task automatic issue(input logic [7:0] op, input logic [15:0] d, input logic [7:0] exp_resp,
                         input string tag);
        accept(op, d, tag);
        chk({tag, "_send"}, 32'(send_resp), 1);
        chk({tag, "_resp"}, 32'(resp), 32'(exp_resp));
    endtask

    // Samples n cycles starting with the current one; first = 1-based index of first strt_cal.
    task automatic spin(input int n, output int first, output int pulses, output int clrs);
        first  = 0;
        pulses = 0;
        clrs   = 0;
        for (int k = 1; k <= n; k++) begin
            if (strt_cal) begin
                pulses++;
                if (first == 0) first = k;
            end
            if (clr_cmd_rdy) clrs++;
            step();
        end
    endtask

    task automatic finish_cal(input string tag);
        int f, p, c;
        spin(600, f, p, c);
        chk({tag, "_strt_cnt"}, 32'(p), 1);
        cal_done = 1'b1;
        step();
        cal_done = 1'b0;
        #1;
        chk({tag, "_done_send"}, 32'(send_resp), 1);
        chk({tag, "_done_resp"}, 32'(resp), 32'hA5);
    endtask

    // Returns the number of cycles stepped until comm_lost is seen (0 if it never is).
    task automatic wait_trip(output int cyc);
        cyc = 0;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (comm_lost) begin
                cyc = k;
                break;
            end
        end
    endtask

    initial begin
        int first, pulses, clrs, cyc, bad;
        logic [THR_W-1:0] ramp_exp[4];

        vecs[0]  = '{8'h05, 16'h01F4, 8'hA5, 12'h000, 12'h000, 12'h000, 9'd400, 1'b1};
        vecs[1]  = '{8'h02, 16'hFF38, 8'hA5, 12'hF38, 12'h000, 12'h000, 9'd400, 1'b1};
        vecs[2]  = '{8'h03, 16'h0123, 8'hA5, 12'hF38, 12'h123, 12'h000, 9'd400, 1'b1};
        vecs[3]  = '{8'h04, 16'h8ABC, 8'hA5, 12'hF38, 12'h123, 12'hABC, 9'd400, 1'b1};
        vecs[4]  = '{8'h3C, 16'h1234, 8'hEE, 12'hF38, 12'h123, 12'hABC, 9'd400, 1'b1};
        vecs[5]  = '{8'h00, 16'hFFFF, 8'hEE, 12'hF38, 12'h123, 12'hABC, 9'd400, 1'b1};
        vecs[6]  = '{8'h09, 16'h0001, 8'hEE, 12'hF38, 12'h123, 12'hABC, 9'd400, 1'b1};
        vecs[7]  = '{8'h05, 16'h0205, 8'hA5, 12'hF38, 12'h123, 12'hABC, 9'd5,   1'b1};
        vecs[8]  = '{8'h05, 16'h0191, 8'hA5, 12'hF38, 12'h123, 12'hABC, 9'd400, 1'b1};
        vecs[9]  = '{8'h05, 16'h018F, 8'hA5, 12'hF38, 12'h123, 12'hABC, 9'd399, 1'b1};
        vecs[10] = '{8'h05, 16'h0190, 8'hA5, 12'hF38, 12'h123, 12'hABC, 9'd400, 1'b1};
        vecs[11] = '{8'h07, 16'h0000, 8'hA5, 12'h000, 12'h000, 12'h000, 9'd0,   1'b1};
        vecs[12] = '{8'h05, 16'h0014, 8'hA5, 12'h000, 12'h000, 12'h000, 9'd20,  1'b1};
        vecs[13] = '{8'h08, 16'h0000, 8'hA5, 12'h000, 12'h000, 12'h000, 9'd0,   1'b1};
        vecs[14] = '{8'h02, 16'h07FF, 8'hA5, 12'h7FF, 12'h000, 12'h000, 9'd0,   1'b1};
        ramp_exp[0] = 9'd12;
        ramp_exp[1] = 9'd8;
        ramp_exp[2] = 9'd4;
        ramp_exp[3] = 9'd0;

        repeat (3) @(posedge clk);
        #2;
        chk_reset("por");
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].d, vecs[i].resp, $sformatf("v%0d", i));
            chk($sformatf("v%0d_ptch", i), 32'(d_ptch), 32'(vecs[i].p));
            chk($sformatf("v%0d_roll", i), 32'(d_roll), 32'(vecs[i].r));
            chk($sformatf("v%0d_yaw", i), 32'(d_yaw), 32'(vecs[i].y));
            chk($sformatf("v%0d_thrst", i), 32'(thrst), 32'(vecs[i].t));
            chk($sformatf("v%0d_moff", i), 32'(motors_off), 32'(vecs[i].moff));
            step();
        end

        // Calibration: strt_cal 511 cycles after inertial_cal rises, then cal_done responds.
        accept(8'h06, 16'h0000, "cal");
        chk("cal_ical", 32'(inertial_cal), 1);
        chk("cal_moff", 32'(motors_off), 0);
        spin(600, first, pulses, clrs);
        chk("cal_strt_at", 32'(first), 512);
        chk("cal_strt_cnt", 32'(pulses), 1);
        chk("cal_ical_wait", 32'(inertial_cal), 1);
        cal_done = 1'b1;
        step();
        cal_done = 1'b0;
        #1;
        chk("cal_send", 32'(send_resp), 1);
        chk("cal_resp", 32'(resp), 32'hA5);
        chk("cal_ical_off", 32'(inertial_cal), 0);
        chk("cal_moff_on", 32'(motors_off), 0);
        step();

        // SET_YAW during calibration stays pending until calibration completes.
        accept(8'h06, 16'h0000, "pend_cal");
        cmd_rdy = 1'b1;
        cmd     = 8'h04;
        data    = 16'h0055;
        spin(600, first, pulses, clrs);
        chk("pend_no_clr", 32'(clrs), 0);
        chk("pend_strt_cnt", 32'(pulses), 1);
        cal_done = 1'b1;
        #1;
        chk("pend_clr_caldone", 32'(clr_cmd_rdy), 0);
        step();
        cal_done = 1'b0;
        #1;
        chk("pend_cal_send", 32'(send_resp), 1);
        chk("pend_cal_resp", 32'(resp), 32'hA5);
        chk("pend_clr_resp", 32'(clr_cmd_rdy), 0);
        step();
        issue(8'h04, 16'h0055, 8'hA5, "pend_yaw");
        chk("pend_yaw_val", 32'(d_yaw), 32'h055);
        step();

        // MTRS_OFF aborts calibration before the spin-up completes.
        accept(8'h06, 16'h0000, "abt_cal");
        spin(100, first, pulses, clrs);
        issue(8'h08, 16'h0000, 8'hA5, "abt");
        chk("abt_moff", 32'(motors_off), 1);
        chk("abt_ical", 32'(inertial_cal), 0);
        spin(600, first, pulses, clrs);
        chk("abt_no_strt", 32'(pulses), 0);

        // Watchdog: a command in the expiry cycle wins, then a real trip and full ramp-down.
        accept(8'h06, 16'h0000, "wd_cal");
        finish_cal("wd");
        step();
        issue(8'h05, 16'h0014, 8'hA5, "wd_thr");
        bad = 0;
        for (int k = 1; k <= 64; k++) begin
            step();
            if (comm_lost) bad++;
        end
        chk("wd_no_early_trip", 32'(bad), 0);
        issue(8'h03, 16'h0011, 8'hA5, "wd_coinc");
        chk("wd_coinc_lost", 32'(comm_lost), 0);
        chk("wd_coinc_roll", 32'(d_roll), 32'h011);
        wait_trip(cyc);
        chk("wd_trip_cycle", 32'(cyc), 65);
        chk("wd_trip_thrst", 32'(thrst), 20);
        chk("wd_trip_ptch", 32'(d_ptch), 0);
        chk("wd_trip_roll", 32'(d_roll), 0);
        chk("wd_trip_yaw", 32'(d_yaw), 0);
        chk("wd_trip_moff", 32'(motors_off), 0);
        repeat (7) step();
        chk("ramp_pre", 32'(thrst), 20);
        step();
        chk("ramp_16", 32'(thrst), 16);
        foreach (ramp_exp[i]) begin
            repeat (8) step();
            chk($sformatf("ramp_%0d", ramp_exp[i]), 32'(thrst), 32'(ramp_exp[i]));
            chk($sformatf("ramp_moff_%0d", ramp_exp[i]), 32'(motors_off),
                (ramp_exp[i] == 0) ? 32'd1 : 32'd0);
        end
        repeat (20) step();
        chk("ramp_end_lost", 32'(comm_lost), 1);
        chk("ramp_end_thrst", 32'(thrst), 0);
        chk("ramp_end_moff", 32'(motors_off), 1);

        // A command during the ramp clears comm_lost and freezes thrust.
        accept(8'h06, 16'h0000, "rc_cal");
        chk("rc_cal_lost", 32'(comm_lost), 0);
        finish_cal("rc");
        step();
        issue(8'h05, 16'h0014, 8'hA5, "rc_thr");
        wait_trip(cyc);
        chk("rc_tripped", 32'(cyc != 0), 1);
        repeat (8) step();
        chk("rc_ramp_16", 32'(thrst), 16);
        repeat (3) step();
        issue(8'h02, 16'h0010, 8'hA5, "rc_cmd");
        chk("rc_lost_clr", 32'(comm_lost), 0);
        chk("rc_thrst", 32'(thrst), 16);
        chk("rc_ptch", 32'(d_ptch), 32'h010);
        repeat (20) step();
        chk("rc_frozen", 32'(thrst), 16);
        chk("rc_still_ok", 32'(comm_lost), 0);

        // Asynchronous reset during CAL_WAIT; a later cal_done is ignored.
        accept(8'h06, 16'h0000, "rst_cal");
        spin(600, first, pulses, clrs);
        chk("rst_strt_cnt", 32'(pulses), 1);
        rst_n = 1'b0;
        #1;
        chk_reset("async");
        step();
        rst_n = 1'b1;
        step();
        cal_done = 1'b1;
        step();
        cal_done = 1'b0;
        #1;
        chk("rst_late_send", 32'(send_resp), 0);
        chk("rst_late_ical", 32'(inertial_cal), 0);
        chk("rst_late_moff", 32'(motors_off), 1);
        chk("rst_late_resp", 32'(resp), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
